// File: rtl/layer_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// layer_seq : walks the (frame, patch) grid of one layer, handshaking each patch with the PE array
// Rev 1.0
// ---------------------------------------------------------------------------
module layer_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        TOP_Sta,
  input  logic        Rst_Layer,
  input  logic [7:0]  CFG_NumPat,
  input  logic [7:0]  CFG_NumFrm,
  input  logic        GBF_Val,
  output logic        PE_Req,
  input  logic        PE_Ack,
  input  logic        PE_Done,
  output logic [7:0]  Pat_Idx,
  output logic [7:0]  Frm_Idx,
  output logic        Busy,
  output logic        Layer_Done,
  output logic [15:0] Cyc_Cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RUN     = 3'd2,
    NEXT    = 3'd3,
    WAITGBF = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] num_pat;
  logic [7:0] num_frm;
  logic       pat_last;
  logic       frm_last;
  logic       start;

  // NEXT is only reachable with both counts >= 1, so the minus-one cannot underflow there
  assign pat_last = (Pat_Idx == (num_pat - 8'd1));
  assign frm_last = (Frm_Idx == (num_frm - 8'd1));
  assign start    = (state == IDLE) && TOP_Sta;

  always_comb begin
    state_nxt = state;
    if (Rst_Layer) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (TOP_Sta)
            state_nxt = ((CFG_NumPat == 8'd0) || (CFG_NumFrm == 8'd0)) ? DONE : ISSUE;
        end
        ISSUE:   if (PE_Ack)  state_nxt = RUN;
        RUN:     if (PE_Done) state_nxt = NEXT;
        NEXT: begin
          if (!pat_last)      state_nxt = ISSUE;
          else if (!frm_last) state_nxt = WAITGBF;
          else                state_nxt = DONE;
        end
        WAITGBF: if (GBF_Val) state_nxt = ISSUE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      num_pat <= 8'd0;
      num_frm <= 8'd0;
      Pat_Idx <= 8'd0;
      Frm_Idx <= 8'd0;
      Cyc_Cnt <= 16'd0;
    end else begin
      state <= state_nxt;
      if (Rst_Layer) begin
        Pat_Idx <= 8'd0;
        Frm_Idx <= 8'd0;
        Cyc_Cnt <= 16'd0;
      end else begin
        if (start) begin
          num_pat <= CFG_NumPat;
          num_frm <= CFG_NumFrm;
          Pat_Idx <= 8'd0;
          Frm_Idx <= 8'd0;
          Cyc_Cnt <= 16'd0;
        end else if ((state != IDLE) && (Cyc_Cnt != 16'hFFFF)) begin
          Cyc_Cnt <= Cyc_Cnt + 16'd1;
        end
        if (state == NEXT) begin
          if (!pat_last) begin
            Pat_Idx <= Pat_Idx + 8'd1;
          end else if (!frm_last) begin
            Pat_Idx <= 8'd0;
            Frm_Idx <= Frm_Idx + 8'd1;
          end
        end
      end
    end
  end

  assign PE_Req     = (state == ISSUE);
  assign Busy       = (state != IDLE);
  assign Layer_Done = (state == DONE);

endmodule
`default_nettype wire
